// File: rtl/arc_hs_pkg.sv
// arc_hs_pkg: shared state encoding and mode constants for the ARC handshake ack engine
package arc_hs_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        ACK     = 2'd2,
        RELEASE = 2'd3
    } state_t;
    localparam logic MODE_REQ      = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;
endpackage

// File: rtl/arc_ack_gen_if.sv
// arc_ack_gen_if: requester/config inputs and acknowledge outputs of the ack engine
interface arc_ack_gen_if #(
    parameter int NCH       = 2,
    parameter int CNT_W     = 8,
    parameter int ID_W      = 1,
    parameter int CNT_OUT_W = 16
);
    logic                 enable;
    logic                 mode;
    logic [NCH-1:0]       req;
    logic [CNT_W-1:0]     wait_cfg;
    logic [CNT_W-1:0]     pulse_cfg;
    logic [NCH-1:0]       ack;
    logic                 busy;
    logic [ID_W-1:0]      grant_id;
    logic [CNT_OUT_W-1:0] pulse_count;
    modport master (output enable, mode, req, wait_cfg, pulse_cfg, input ack, busy, grant_id, pulse_count);
    modport slave  (input enable, mode, req, wait_cfg, pulse_cfg, output ack, busy, grant_id, pulse_count);
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first set mask bit after ptr
module rr_arbiter #(
    parameter int NCH  = 2,
    parameter int ID_W = 1
) (
    input  logic [NCH-1:0]  req,
    input  logic [ID_W-1:0] ptr,
    output logic [ID_W-1:0] pick,
    output logic            valid
);
    // scan farthest offset first so the nearest set bit after ptr wins
    always_comb begin
        pick  = '0;
        valid = 1'b0;
        for (int i = NCH; i >= 1; i--) begin
            if (req[(int'(ptr) + i) % NCH]) begin
                pick  = ID_W'((int'(ptr) + i) % NCH);
                valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/arc_ack_gen.sv
// arc_ack_gen: programmable wait-state / pulse-length acknowledge engine with round-robin grant
module arc_ack_gen
    import arc_hs_pkg::*;
#(
    parameter int NCH       = 2,
    parameter int CNT_W     = 8,
    parameter int ID_W      = 1,
    parameter int CNT_OUT_W = 16
) (
    input logic          clk,
    input logic          rst,
    arc_ack_gen_if.slave bus
);
    state_t               state, state_d;
    logic [CNT_W-1:0]     cnt, cnt_d, pulse_q, pulse_d;
    logic [ID_W-1:0]      rr_ptr, rr_d, grant, grant_d, win, nxt;
    logic [NCH-1:0]       ack, ack_d, mask;
    logic [CNT_OUT_W-1:0] pcount, pcount_d;
    logic                 mode_q, mode_d, win_valid;
    // periodic mode ignores req, so every channel is a candidate
    assign mask = (bus.mode == MODE_PERIODIC) ? '1 : bus.req;
    assign nxt  = (rr_ptr == ID_W'(NCH - 1)) ? '0 : rr_ptr + ID_W'(1);
    rr_arbiter #(.NCH(NCH), .ID_W(ID_W)) u_arb (
        .req   (mask),
        .ptr   (rr_ptr),
        .pick  (win),
        .valid (win_valid)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            pulse_q <= '0;
            rr_ptr  <= ID_W'(NCH - 1);
            grant   <= '0;
            ack     <= '0;
            pcount  <= '0;
            mode_q  <= MODE_REQ;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            pulse_q <= pulse_d;
            rr_ptr  <= rr_d;
            grant   <= grant_d;
            ack     <= ack_d;
            pcount  <= pcount_d;
            mode_q  <= mode_d;
        end
    end
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        pulse_d  = pulse_q;
        rr_d     = rr_ptr;
        grant_d  = grant;
        ack_d    = ack;
        pcount_d = pcount;
        mode_d   = mode_q;
        case (state)
            IDLE: if (bus.enable && win_valid) begin
                state_d = WAIT;
                grant_d = win;
                rr_d    = win;
                cnt_d   = bus.wait_cfg;
                pulse_d = bus.pulse_cfg;
                mode_d  = bus.mode;
            end
            WAIT: if (!bus.enable || (mode_q == MODE_REQ && !bus.req[grant])) begin
                state_d = IDLE;
            end else if (cnt == '0) begin
                state_d  = ACK;
                cnt_d    = (pulse_q == '0) ? '0 : pulse_q - CNT_W'(1);
                pcount_d = pcount + CNT_OUT_W'(1);
                ack_d    = NCH'(1) << grant;
            end else begin
                cnt_d = cnt - CNT_W'(1);
            end
            ACK: if (cnt == '0) begin
                ack_d = '0;
                if (mode_q == MODE_REQ) begin
                    state_d = RELEASE;
                end else if (!bus.enable) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT;
                    grant_d = nxt;
                    rr_d    = nxt;
                    cnt_d   = bus.wait_cfg;
                    pulse_d = bus.pulse_cfg;
                end
            end else begin
                cnt_d = cnt - CNT_W'(1);
            end
            RELEASE: if (!bus.req[grant]) state_d = IDLE;
        endcase
    end
    assign bus.ack         = ack;
    assign bus.busy        = state != IDLE;
    assign bus.grant_id    = grant;
    assign bus.pulse_count = pcount;
endmodule

// File: tb/tb_arc_ack_gen.sv
// tb_arc_ack_gen: directed self-checking bench with an ack scoreboard for arc_ack_gen
module tb_arc_ack_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   exp_q[$];
    int   e_ch;
    logic [1:0] prev_ack = '0;
    always #5 clk = ~clk;
    arc_ack_gen_if #(.NCH(2), .CNT_W(8), .ID_W(1), .CNT_OUT_W(4)) bus ();
    arc_ack_gen #(.NCH(2), .CNT_W(8), .ID_W(1), .CNT_OUT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask
    // scoreboard: each ack rising edge must match the next queued channel
    always @(negedge clk) begin
        if (bus.ack != 2'b00 && prev_ack == 2'b00) begin
            if (exp_q.size() == 0) chk("unexpected_ack", 32'(bus.ack), 0);
            else begin
                e_ch = exp_q.pop_front();
                chk("sb_ack", 32'(bus.ack), 32'(1) << e_ch);
                chk("sb_grant", 32'(bus.grant_id), 32'(e_ch));
            end
        end
        chk("ack_onehot0", 32'($onehot0(bus.ack)), 1);
        prev_ack = bus.ack;
    end
    initial begin
        bus.enable = 1'b0; bus.mode = 1'b0; bus.req = 2'b00; bus.wait_cfg = 8'd0; bus.pulse_cfg = 8'd0;
        tick(2);
        chk("rst_ack", 32'(bus.ack), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_grant", 32'(bus.grant_id), 0);
        chk("rst_pcount", 32'(bus.pulse_count), 0);
        rst = 1'b0;
        tick(1);
        // simultaneous requests, wait 0, pulse 1: ch0 then ch1
        exp_q.push_back(0); exp_q.push_back(1);
        bus.enable = 1'b1; bus.wait_cfg = 8'd0; bus.pulse_cfg = 8'd1; bus.req = 2'b11;
        tick(1);
        chk("sim_wait_busy", 32'(bus.busy), 1);
        chk("sim_wait_ack", 32'(bus.ack), 0);
        tick(1);
        chk("sim_ack0", 32'(bus.ack), 32'h1);
        bus.req = 2'b10;
        tick(1);
        chk("sim_ack0_end", 32'(bus.ack), 0);
        chk("sim_release_busy", 32'(bus.busy), 1);
        tick(1);
        chk("sim_idle", 32'(bus.busy), 0);
        tick(1);
        chk("sim_grant1", 32'(bus.grant_id), 1);
        tick(1);
        chk("sim_ack1", 32'(bus.ack), 32'h2);
        bus.req = 2'b00;
        tick(1);
        chk("sim_ack1_end", 32'(bus.ack), 0);
        tick(1);
        chk("sim_done_busy", 32'(bus.busy), 0);
        chk("sim_pcount", 32'(bus.pulse_count), 2);
        // request mode, wait 10, pulse 2
        exp_q.push_back(0);
        bus.wait_cfg = 8'd10; bus.pulse_cfg = 8'd2; bus.req = 2'b01;
        tick(1);
        chk("req_wait_busy", 32'(bus.busy), 1);
        tick(10);
        chk("req_e10_ack", 32'(bus.ack), 0);
        bus.wait_cfg = 8'd3; bus.pulse_cfg = 8'd7;
        tick(1);
        chk("req_e11_ack", 32'(bus.ack), 32'h1);
        tick(1);
        chk("req_e12_ack", 32'(bus.ack), 32'h1);
        tick(1);
        chk("req_e13_ack", 32'(bus.ack), 0);
        chk("req_pcount", 32'(bus.pulse_count), 3);
        tick(3);
        chk("req_release_hold", 32'(bus.busy), 1);
        chk("req_release_ack", 32'(bus.ack), 0);
        bus.req = 2'b00;
        tick(1);
        chk("req_idle", 32'(bus.busy), 0);
        // abort: ch1 drops in WAIT
        bus.wait_cfg = 8'd10; bus.req = 2'b10;
        tick(1);
        chk("abort_busy", 32'(bus.busy), 1);
        chk("abort_grant", 32'(bus.grant_id), 1);
        tick(5);
        bus.req = 2'b00;
        tick(1);
        chk("abort_idle", 32'(bus.busy), 0);
        chk("abort_pcount", 32'(bus.pulse_count), 3);
        tick(12);
        chk("abort_no_ack", 32'(bus.ack), 0);
        // periodic: 5 pulses alternating ch0/ch1, 13-cycle period
        for (int k = 0; k < 5; k++) exp_q.push_back(k % 2);
        bus.mode = 1'b1; bus.wait_cfg = 8'd10; bus.pulse_cfg = 8'd2;
        tick(11);
        for (int k = 0; k < 5; k++) begin
            tick(1);
            chk("per_rise", 32'(bus.ack), 32'(1) << (k % 2));
            chk("per_pcount", 32'(bus.pulse_count), 32'((4 + k) % 16));
            if (k == 4) bus.enable = 1'b0;
            tick(1);
            chk("per_hold", 32'(bus.ack), 32'(1) << (k % 2));
            tick(1);
            chk("per_fall", 32'(bus.ack), 0);
            if (k < 4) tick(10);
        end
        chk("per_idle", 32'(bus.busy), 0);
        chk("per_pcount_end", 32'(bus.pulse_count), 8);
        // pulse_cfg=0 gives a 1-cycle ack; 8 more pulses wrap the 4-bit counter
        for (int k = 0; k < 8; k++) exp_q.push_back((k + 1) % 2);
        bus.wait_cfg = 8'd0; bus.pulse_cfg = 8'd0; bus.enable = 1'b1;
        tick(1);
        for (int k = 0; k < 8; k++) begin
            tick(1);
            chk("p0_ack", 32'(bus.ack), 32'(1) << ((k + 1) % 2));
            chk("p0_pcount", 32'(bus.pulse_count), 32'((9 + k) % 16));
            if (k == 7) bus.enable = 1'b0;
            tick(1);
            chk("p0_fall", 32'(bus.ack), 0);
        end
        chk("wrap_pcount", 32'(bus.pulse_count), 0);
        chk("wrap_idle", 32'(bus.busy), 0);
        // async reset in the middle of an ack pulse
        exp_q.push_back(1);
        bus.mode = 1'b0; bus.wait_cfg = 8'd0; bus.pulse_cfg = 8'd5; bus.req = 2'b10; bus.enable = 1'b1;
        tick(2);
        chk("mid_ack", 32'(bus.ack), 32'h2);
        chk("mid_pcount", 32'(bus.pulse_count), 1);
        tick(1);
        #2 rst = 1'b1;
        #1;
        chk("arst_ack", 32'(bus.ack), 0);
        chk("arst_busy", 32'(bus.busy), 0);
        chk("arst_grant", 32'(bus.grant_id), 0);
        chk("arst_pcount", 32'(bus.pulse_count), 0);
        @(negedge clk);
        rst = 1'b0; bus.req = 2'b00;
        tick(2);
        chk("post_rst_busy", 32'(bus.busy), 0);
        chk("post_rst_pcount", 32'(bus.pulse_count), 0);
        chk("sb_drained", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
